// File: rtl/rv_dm_wb_bridge_pkg.sv
// Shared definitions for the uRV data-memory to Wishbone bridge:
// FSM encoding, default error read data and the latched request record.
package rv_defs;

  typedef enum logic {
    BRIDGE_IDLE = 1'b0,
    BRIDGE_BUS  = 1'b1
  } bridge_state_e;

  localparam logic [31:0] RV_BUS_ERR_DATA = 32'h0000_0000;

  // Everything driven onto the bus for one transaction, held for its duration.
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } wb_req_t;

  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/rv_dm_wb_bridge.sv
// Bridges single uRV data-memory loads/stores onto Wishbone B4 classic cycles,
// with a per-transaction timeout and a sticky error flag.
module rv_dm_wb_bridge
  import rv_defs::*;
#(
  parameter int unsigned g_timeout  = 255,
  parameter logic [31:0] g_err_data = RV_BUS_ERR_DATA
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        bus_err_o,
  input  logic        bus_err_clr_i
);

  localparam bit TIMEOUT_EN = (g_timeout != 0);
  localparam int CNT_W      = TIMEOUT_EN ? $clog2(g_timeout + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = TIMEOUT_EN ? CNT_W'(g_timeout) : '0;
  localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(g_timeout - 1) : '0;

  bridge_state_e state_q, state_d;
  wb_req_t       req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]   data_l_q, data_l_d;
  logic          ld_done_q, ld_done_d;
  logic          st_done_q, st_done_d;
  logic          err_q, err_d;
  logic          err_set;
  logic          timeout;

  // NOTE: every variable gets a default before the case statement so no path
  // leaves it unassigned; that is what keeps this block free of latches.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    cnt_d     = cnt_q;
    data_l_d  = data_l_q;
    ld_done_d = 1'b0;
    st_done_d = 1'b0;
    err_set   = 1'b0;
    timeout   = 1'b0;

    case (state_q)
      BRIDGE_IDLE: begin
        if (dm_load_i || dm_store_i) begin
          state_d = BRIDGE_BUS;
          req_d   = '{adr: word_addr(dm_addr_i), dat: dm_data_s_i,
                      sel: dm_data_select_i, we: dm_store_i};
          cnt_d   = '0;
          // A store wins over a same-cycle load; the dropped load is an error.
          err_set = dm_load_i && dm_store_i;
        end
      end

      BRIDGE_BUS: begin
        if (TIMEOUT_EN && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
        timeout = TIMEOUT_EN && (cnt_q == CNT_LAST);
        if (wb_ack_i || wb_err_i || timeout) begin
          state_d   = BRIDGE_IDLE;
          ld_done_d = !req_q.we;
          st_done_d = req_q.we;
          err_set   = !wb_ack_i;
          if (!req_q.we) data_l_d = wb_ack_i ? wb_dat_i : g_err_data;
        end
      end

      default: state_d = BRIDGE_IDLE;
    endcase

    err_d = err_set ? 1'b1 : (bus_err_clr_i ? 1'b0 : err_q);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= BRIDGE_IDLE;
      req_q     <= '0;
      cnt_q     <= '0;
      data_l_q  <= '0;
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
      data_l_q  <= data_l_d;
      ld_done_q <= ld_done_d;
      st_done_q <= st_done_d;
      err_q     <= err_d;
    end
  end

  assign dm_ready_o      = (state_q == BRIDGE_IDLE);
  assign wb_cyc_o        = (state_q == BRIDGE_BUS);
  assign wb_stb_o        = (state_q == BRIDGE_BUS);
  assign wb_adr_o        = req_q.adr;
  assign wb_dat_o        = req_q.dat;
  assign wb_sel_o        = req_q.sel;
  assign wb_we_o         = req_q.we;
  assign dm_data_l_o     = data_l_q;
  assign dm_load_done_o  = ld_done_q;
  assign dm_store_done_o = st_done_q;
  assign bus_err_o       = err_q;

endmodule

// File: tb/tb_rv_dm_wb_bridge.sv
// Self-checking bench for rv_dm_wb_bridge: directed scenarios plus random
// traffic compared every cycle against a transaction-level model.
module tb_rv_dm_wb_bridge;
  import rv_defs::*;

  localparam int unsigned TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] dm_addr_i, dm_data_s_i, wb_dat_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_load_i, dm_store_i, wb_ack_i, wb_err_i, bus_err_clr_i;
  logic        dm_ready_o, dm_load_done_o, dm_store_done_o;
  logic [31:0] dm_data_l_o, wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, bus_err_o;

  int n_checks = 0;
  int n_errors = 0;

  rv_dm_wb_bridge #(.g_timeout(TO), .g_err_data(RV_BUS_ERR_DATA)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i),
    .dm_data_select_i(dm_data_select_i),
    .dm_load_i(dm_load_i), .dm_store_i(dm_store_i),
    .dm_ready_o(dm_ready_o), .dm_data_l_o(dm_data_l_o),
    .dm_load_done_o(dm_load_done_o), .dm_store_done_o(dm_store_done_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .bus_err_o(bus_err_o), .bus_err_clr_i(bus_err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding request, its age in bus cycles,
  // and what the core should observe in the current cycle.
  bit          m_busy, m_we, m_ld_done, m_st_done, m_err;
  logic [31:0] m_adr, m_dat, m_data_l;
  logic [3:0]  m_sel;
  int          m_cycles;

  task automatic model_reset();
    m_busy = 0; m_we = 0; m_ld_done = 0; m_st_done = 0; m_err = 0;
    m_adr = '0; m_dat = '0; m_data_l = '0; m_sel = '0; m_cycles = 0;
  endtask

  // Called just after a rising edge, with the inputs seen at that edge.
  task automatic model_step();
    bit set_err;
    if (rst_i) begin
      model_reset();
      return;
    end
    set_err = 0;
    m_ld_done = 0;
    m_st_done = 0;
    if (m_busy) begin
      m_cycles++;
      if (wb_ack_i || wb_err_i || (TO != 0 && m_cycles == int'(TO))) begin
        m_busy = 0;
        if (m_we) m_st_done = 1;
        else begin
          m_ld_done = 1;
          m_data_l  = wb_ack_i ? wb_dat_i : RV_BUS_ERR_DATA;
        end
        if (!wb_ack_i) set_err = 1;
      end
    end else if (dm_load_i || dm_store_i) begin
      m_busy = 1; m_we = dm_store_i; m_cycles = 0;
      m_adr = {dm_addr_i[31:2], 2'b00}; m_dat = dm_data_s_i; m_sel = dm_data_select_i;
      if (dm_load_i && dm_store_i) set_err = 1;
    end
    if (set_err) m_err = 1;
    else if (bus_err_clr_i) m_err = 0;
  endtask

  always @(negedge clk_i) begin
    check("ready", 32'(dm_ready_o), 32'(!m_busy));
    check("cyc", 32'(wb_cyc_o), 32'(m_busy));
    check("stb", 32'(wb_stb_o), 32'(m_busy));
    check("load_done", 32'(dm_load_done_o), 32'(m_ld_done));
    check("store_done", 32'(dm_store_done_o), 32'(m_st_done));
    check("data_l", dm_data_l_o, m_data_l);
    check("bus_err", 32'(bus_err_o), 32'(m_err));
    if (m_busy) begin
      check("adr", wb_adr_o, m_adr);
      check("dat", wb_dat_o, m_dat);
      check("sel", 32'(wb_sel_o), 32'(m_sel));
      check("we", 32'(wb_we_o), 32'(m_we));
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    model_step();
  endtask

  task automatic idle_inputs();
    dm_load_i = 0; dm_store_i = 0; bus_err_clr_i = 0;
    wb_ack_i = 0; wb_err_i = 0;
  endtask

  int  cyc_cnt;
  bit  seen;

  initial begin
    rst_i = 1'b1;
    dm_addr_i = '0; dm_data_s_i = '0; dm_data_select_i = '0; wb_dat_i = '0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", 32'(dm_ready_o), 32'd1);
    check("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_data_l", dm_data_l_o, 32'd0);
    check("rst_err", 32'(bus_err_o), 32'd0);
    #2 rst_i = 1'b0;
    tick();

    // Load with three wait states; the ack lands on the last timeout cycle.
    dm_load_i = 1; dm_addr_i = 32'h0000_1006;
    tick();
    dm_load_i = 0;
    check("t1_adr", wb_adr_o, 32'h0000_1004);
    check("t1_we", 32'(wb_we_o), 32'd0);
    tick();
    tick();
    tick();
    wb_ack_i = 1; wb_dat_i = 32'hCAFE_F00D;
    tick();
    wb_ack_i = 0;
    check("t1_done", 32'(dm_load_done_o), 32'd1);
    check("t1_data", dm_data_l_o, 32'hCAFE_F00D);
    check("t1_err", 32'(bus_err_o), 32'd0);
    tick();
    check("t1_single_pulse", 32'(dm_load_done_o), 32'd0);

    // Zero-wait store followed by a back-to-back load.
    dm_store_i = 1; dm_addr_i = 32'h0000_2001; dm_data_s_i = 32'h1234_5678;
    dm_data_select_i = 4'b0011;
    tick();
    dm_store_i = 0; wb_ack_i = 1;
    check("t2_we", 32'(wb_we_o), 32'd1);
    check("t2_sel", 32'(wb_sel_o), 32'h3);
    check("t2_dat", wb_dat_o, 32'h1234_5678);
    tick();
    wb_ack_i = 0;
    check("t2_store_done", 32'(dm_store_done_o), 32'd1);
    check("t2_ready", 32'(dm_ready_o), 32'd1);
    dm_load_i = 1; dm_addr_i = 32'h0000_3008;
    tick();
    dm_load_i = 0;
    check("t2_b2b_cyc", 32'(wb_cyc_o), 32'd1);
    check("t2_b2b_adr", wb_adr_o, 32'h0000_3008);
    wb_ack_i = 1; wb_dat_i = 32'h0BAD_F00D;
    tick();
    wb_ack_i = 0;
    check("t2_b2b_data", dm_data_l_o, 32'h0BAD_F00D);
    tick();

    // Silent slave: timeout after TO bus cycles.
    dm_load_i = 1; dm_addr_i = 32'h0000_5008; wb_dat_i = 32'h7777_7777;
    cyc_cnt = 0; seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      dm_load_i = 0;
      if (wb_cyc_o) cyc_cnt++;
      if (dm_load_done_o) begin
        seen = 1;
        check("t3_data", dm_data_l_o, 32'h0000_0000);
      end
    end
    check("t3_done_seen", 32'(seen), 32'd1);
    check("t3_cyc_cycles", 32'(cyc_cnt), 32'd4);
    check("t3_err", 32'(bus_err_o), 32'd1);
    tick();
    tick();
    check("t3_err_sticky", 32'(bus_err_o), 32'd1);
    bus_err_clr_i = 1;
    tick();
    bus_err_clr_i = 0;
    check("t3_err_cleared", 32'(bus_err_o), 32'd0);

    // Ack and err together: ack wins.
    dm_load_i = 1; dm_addr_i = 32'h0000_6000;
    tick();
    dm_load_i = 0; wb_ack_i = 1; wb_err_i = 1; wb_dat_i = 32'hA5A5_A5A5;
    tick();
    wb_ack_i = 0; wb_err_i = 0;
    check("t4_data", dm_data_l_o, 32'hA5A5_A5A5);
    check("t4_err", 32'(bus_err_o), 32'd0);

    // Load and store together, with a clear in the same cycle: set wins.
    dm_load_i = 1; dm_store_i = 1; bus_err_clr_i = 1;
    dm_addr_i = 32'h0000_4000; dm_data_s_i = 32'hDEAD_BEEF; dm_data_select_i = 4'hF;
    tick();
    idle_inputs();
    check("t5_err_set_wins", 32'(bus_err_o), 32'd1);
    check("t5_we", 32'(wb_we_o), 32'd1);
    wb_ack_i = 1;
    tick();
    wb_ack_i = 0;
    check("t5_store_done", 32'(dm_store_done_o), 32'd1);
    check("t5_no_load_done", 32'(dm_load_done_o), 32'd0);
    bus_err_clr_i = 1;
    tick();
    bus_err_clr_i = 0;

    // Reset in the middle of a bus cycle.
    dm_load_i = 1; dm_addr_i = 32'h0000_7000;
    tick();
    dm_load_i = 0;
    check("t6_cyc_before", 32'(wb_cyc_o), 32'd1);
    #2 rst_i = 1'b1;
    model_reset();
    #1;
    check("t6_cyc_async", 32'(wb_cyc_o), 32'd0);
    check("t6_stb_async", 32'(wb_stb_o), 32'd0);
    @(posedge clk_i);
    #3 rst_i = 1'b0;
    tick();
    check("t6_ready", 32'(dm_ready_o), 32'd1);
    check("t6_no_done", 32'(dm_load_done_o), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      dm_load_i        = ($urandom_range(3) == 0);
      dm_store_i       = ($urandom_range(4) == 0);
      dm_addr_i        = $urandom;
      dm_data_s_i      = $urandom;
      dm_data_select_i = 4'($urandom);
      bus_err_clr_i    = ($urandom_range(15) == 0);
      wb_dat_i         = $urandom;
      wb_ack_i         = wb_cyc_o && ($urandom_range(3) == 0);
      wb_err_i         = wb_cyc_o && ($urandom_range(5) == 0);
      tick();
    end
    idle_inputs();
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
